// File: rtl/io_page_access.sv
// io_page_access: one memory-mapped I/O read or write per start, with req/ack handshake and timeout
module io_page_access #(
    parameter logic [3:0] PAGE    = 4'hF,
    parameter int         TIMEOUT = 16,
    parameter int         CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        start,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [11:0] io_addr,
    output logic [15:0] io_wdata,
    input  logic        io_ack,
    input  logic [15:0] io_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic busy_nx, done_nx, err_nx, io_req_nx, io_we_nx;
    logic [15:0] rdata_nx, io_wdata_nx;
    logic [11:0] io_addr_nx;
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            io_req   <= 1'b0;
            io_we    <= 1'b0;
            io_addr  <= '0;
            io_wdata <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            err      <= err_nx;
            rdata    <= rdata_nx;
            io_req   <= io_req_nx;
            io_we    <= io_we_nx;
            io_addr  <= io_addr_nx;
            io_wdata <= io_wdata_nx;
        end
    end
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        busy_nx     = busy;
        done_nx     = 1'b0;
        err_nx      = err;
        rdata_nx    = rdata;
        io_req_nx   = io_req;
        io_we_nx    = io_we;
        io_addr_nx  = io_addr;
        io_wdata_nx = io_wdata;
        case (state)
            IDLE: if (start) begin
                busy_nx = 1'b1;
                if (addr[15:12] == PAGE) begin
                    err_nx      = 1'b0;
                    io_req_nx   = 1'b1;
                    io_we_nx    = we;
                    io_addr_nx  = addr[11:0];
                    io_wdata_nx = wdata;
                    cnt_nx      = '0;
                    state_nx    = ACCESS;
                end else begin
                    err_nx   = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = RESP;
                end
            end
            ACCESS: begin
                // ack beats the terminal count when both land on the same edge
                if (io_ack) begin
                    io_req_nx = 1'b0;
                    err_nx    = 1'b0;
                    rdata_nx  = io_we ? rdata : io_rdata;
                    done_nx   = 1'b1;
                    state_nx  = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    io_req_nx = 1'b0;
                    err_nx    = 1'b1;
                    done_nx   = 1'b1;
                    state_nx  = RESP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RESP: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                busy_nx   = 1'b0;
                io_req_nx = 1'b0;
                state_nx  = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_io_page_access.sv
// tb_io_page_access: directed and random transactions against a transaction-level model
module tb_io_page_access;
    localparam int TO = 16;
    logic        CLK = 1'b0, RST_n = 1'b0;
    logic        start = 1'b0, we = 1'b0, io_ack = 1'b0;
    logic [15:0] addr = '0, wdata = '0, io_rdata = '0;
    logic        busy, done, err, io_req, io_we;
    logic [15:0] rdata, io_wdata;
    logic [11:0] io_addr;
    int checks = 0, errors = 0;
    logic [15:0] m_rdata = '0;
    logic        m_err = 1'b0;

    io_page_access dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata), .io_req(io_req), .io_we(io_we),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_req"}, io_req, 0);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_rdata"}, rdata, m_rdata);
    endtask

    // ack_at = wait cycles before ack; ack_at >= TO means the peripheral never answers
    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input int ack_at, input bit hold);
        logic [15:0] rd;
        bit fin, ack;
        int k;
        start = 1'b1; we = w; addr = a; wdata = d; io_ack = 1'b0;
        tick();
        if (!hold) start = 1'b0;
        if (a[15:12] != 4'hF) begin
            m_err = 1'b1;
            chk("bp_req", io_req, 0);
            chk("bp_busy", busy, 1);
            chk("bp_done", done, 1);
            chk("bp_err", err, 1);
            chk("bp_rdata", rdata, m_rdata);
        end else begin
            m_err = 1'b0;
            chk("acc_req", io_req, 1);
            chk("acc_busy", busy, 1);
            chk("acc_done", done, 0);
            chk("acc_err", err, 0);
            chk("acc_addr", io_addr, a[11:0]);
            chk("acc_we", io_we, w);
            chk("acc_wdata", io_wdata, d);
            fin = 0;
            k = 0;
            while (!fin && k < TO) begin
                k++;
                ack = (k - 1 == ack_at);
                rd = 16'($urandom);
                io_ack = ack;
                io_rdata = rd;
                tick();
                io_ack = 1'b0;
                if (ack) begin
                    m_err = 1'b0;
                    if (!w) m_rdata = rd;
                end else if (k == TO) m_err = 1'b1;
                if (ack || k == TO) begin
                    fin = 1;
                    chk("end_done", done, 1);
                    chk("end_req", io_req, 0);
                    chk("end_busy", busy, 1);
                    chk("end_err", err, m_err);
                    chk("end_rdata", rdata, m_rdata);
                end else begin
                    chk("wait_req", io_req, 1);
                    chk("wait_done", done, 0);
                    chk("wait_addr", io_addr, a[11:0]);
                    chk("wait_we", io_we, w);
                    chk("wait_wdata", io_wdata, d);
                end
            end
        end
        tick();
        start = 1'b0;
        idle_chk("ret");
    endtask

    initial begin
        #2;
        idle_chk("rst");
        chk("rst_we", io_we, 0);
        chk("rst_addr", io_addr, 0);
        chk("rst_wdata", io_wdata, 0);
        #10 RST_n = 1'b1;
        tick();
        idle_chk("post_rst");
        txn(1'b0, 16'hF123, 16'h0000, 0, 0);
        chk("t1_rdata", rdata, m_rdata);
        txn(1'b1, 16'hF00A, 16'h5A5A, 3, 0);
        txn(1'b0, 16'hF200, 16'h0000, 100, 0);
        txn(1'b0, 16'hF201, 16'h0000, TO - 1, 0);
        txn(1'b0, 16'h7123, 16'h0000, 0, 0);
        txn(1'b0, 16'hF124, 16'h0000, 1, 0);
        txn(1'b1, 16'hF333, 16'hA5A5, 2, 1);
        tick();
        idle_chk("hold_idle");
        io_ack = 1'b1;
        io_rdata = 16'hDEAD;
        tick();
        io_ack = 1'b0;
        idle_chk("idle_ack");
        start = 1'b1; we = 1'b0; addr = 16'hF055;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 RST_n = 1'b0;
        #1;
        m_rdata = '0;
        m_err = 1'b0;
        idle_chk("async_rst");
        #4 RST_n = 1'b1;
        tick();
        idle_chk("rst_release");
        txn(1'b0, 16'hF0F0, 16'h0000, 2, 0);
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            a[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            txn(1'($urandom), a, 16'($urandom), int'($urandom_range(0, TO + 3)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                io_ack = 1'b1;
                io_rdata = 16'($urandom);
                tick();
                io_ack = 1'b0;
                idle_chk("rnd_idle_ack");
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
